// File: rtl/oled_pkg.sv
// Shared constants, state encoding and glyph-width helper for the OLED text renderer.
package oled_pkg;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COLL_BASE = 8'h00;
  localparam logic [7:0] CMD_COLH_BASE = 8'h10;

  localparam int OLED_COLS      = 128;
  localparam int GLYPH_W_NARROW = 8;
  localparam int GLYPH_W_WIDE   = 16;

  // Glyph codes at or above this value have no ROM entry and render as blank columns.
  localparam logic [5:0] CODE_INVALID_MIN = 6'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_PAGE,
    ST_CMD_COLL,
    ST_CMD_COLH,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_NEXT_ROW,
    ST_DONE
  } oled_state_t;

  // Wide (16-column) glyphs are the Chinese characters stored in the font ROM.
  function automatic logic is_wide_code(input logic [5:0] code);
    case (code)
      6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11: is_wide_code = 1'b1;
      default:                                   is_wide_code = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oled_byte_skid.sv
// One-entry output register: holds a presented byte stable until the consumer accepts it.
module oled_byte_skid
  import oled_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_dc,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_dc,
  input  logic       i_outReady
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_dc;

  assign o_ready = !r_valid || i_outReady;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dc    = r_dc;

  // Load only when empty or draining this cycle, so a stalled byte never changes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_dc    <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_dc   <= i_dc;
      end
    end
  end

endmodule

// File: rtl/oled_text_render.sv
// Renders a line of glyphs from the font ROM onto two SSD1306 pages as a command/data byte stream.
module oled_text_render
  import oled_pkg::*;
#(
  parameter int MAX_SLOTS = 8,
  parameter int ROM_LAT   = 2
)
(
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             line_page,
  input  logic [6:0]             start_col,
  input  logic [3:0]             glyph_cnt,
  input  logic [6*MAX_SLOTS-1:0] glyph_bus,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             font_sel,
  output logic                   font_row,
  output logic [8:0]             index,
  input  logic [7:0]             font_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_dc
);

  localparam int SLOT_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

  oled_state_t r_state, w_nextState;

  logic [2:0] r_page;
  logic [6:0] r_startCol;
  logic [3:0] r_cnt;
  logic [5:0] r_codes [MAX_SLOTS];
  logic       r_row;
  logic [3:0] r_slot;
  logic [3:0] r_glyphIdx;
  logic [7:0] r_col;
  logic       r_invalid;
  logic [3:0] r_wait;
  logic [5:0] r_fontSel;
  logic       r_fontRow;
  logic [8:0] r_index;

  logic       w_pushValid;
  logic [7:0] w_pushData;
  logic       w_pushDc;
  logic       w_pushReady;
  logic       w_skidValid;
  logic [5:0] w_code;
  logic       w_wide;
  logic       w_lastCol;
  logic [3:0] w_nextSlot;
  logic [7:0] w_nextCol;
  logic       w_moreAfter;
  logic [3:0] w_cntClamped;
  logic       w_lastRow;

  assign w_code       = r_codes[r_slot[SLOT_W-1:0]];
  assign w_wide       = is_wide_code(w_code);
  assign w_lastCol    = w_wide ? (r_glyphIdx == 4'(GLYPH_W_WIDE - 1))
                               : (r_glyphIdx == 4'(GLYPH_W_NARROW - 1));
  assign w_nextSlot   = w_lastCol ? (r_slot + 4'd1) : r_slot;
  assign w_nextCol    = r_col + 8'd1;
  // Stop the row once every slot is drawn or the panel's right edge has been passed.
  assign w_moreAfter  = (w_nextSlot < r_cnt) && (w_nextCol < 8'(OLED_COLS));
  assign w_cntClamped = (glyph_cnt > 4'(MAX_SLOTS)) ? 4'(MAX_SLOTS) : glyph_cnt;
  assign w_lastRow    = r_row || (r_page == 3'd7);

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign font_sel = r_fontSel;
  assign font_row = r_fontRow;
  assign index    = r_index;
  assign out_valid = w_skidValid;

  oled_byte_skid u_skid (
    .i_clk      (sys_clk),
    .i_rst      (rst),
    .i_valid    (w_pushValid),
    .i_data     (w_pushData),
    .i_dc       (w_pushDc),
    .o_ready    (w_pushReady),
    .o_valid    (w_skidValid),
    .o_data     (out_data),
    .o_dc       (out_dc),
    .i_outReady (out_ready)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_pushValid = 1'b0;
    w_pushData  = 8'h00;
    w_pushDc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_nextState = (w_cntClamped == 4'd0) ? ST_DONE : ST_CMD_PAGE;
      end
      ST_CMD_PAGE: begin
        w_pushValid = 1'b1;
        w_pushData  = CMD_PAGE_BASE | {5'd0, r_page};
        if (w_pushReady) w_nextState = ST_CMD_COLL;
      end
      ST_CMD_COLL: begin
        w_pushValid = 1'b1;
        w_pushData  = CMD_COLL_BASE | {4'd0, r_startCol[3:0]};
        if (w_pushReady) w_nextState = ST_CMD_COLH;
      end
      ST_CMD_COLH: begin
        w_pushValid = 1'b1;
        w_pushData  = CMD_COLH_BASE | {5'd0, r_startCol[6:4]};
        if (w_pushReady) w_nextState = ST_FETCH;
      end
      ST_FETCH: w_nextState = ST_WAIT;
      ST_WAIT: begin
        if (r_wait == 4'(ROM_LAT - 1)) w_nextState = ST_EMIT;
      end
      ST_EMIT: begin
        w_pushValid = 1'b1;
        w_pushData  = r_invalid ? 8'h00 : font_data;
        w_pushDc    = 1'b1;
        if (w_pushReady) w_nextState = w_moreAfter ? ST_FETCH : ST_NEXT_ROW;
      end
      // Completion waits for the last byte to leave the output register.
      ST_NEXT_ROW: begin
        if (!w_lastRow)        w_nextState = ST_CMD_PAGE;
        else if (!w_skidValid) w_nextState = ST_DONE;
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_page     <= 3'd0;
      r_startCol <= 7'd0;
      r_cnt      <= 4'd0;
      for (int k = 0; k < MAX_SLOTS; k++) r_codes[k] <= 6'd0;
      r_row      <= 1'b0;
      r_slot     <= 4'd0;
      r_glyphIdx <= 4'd0;
      r_col      <= 8'd0;
      r_invalid  <= 1'b0;
      r_wait     <= 4'd0;
      r_fontSel  <= 6'd0;
      r_fontRow  <= 1'b0;
      r_index    <= 9'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_page     <= line_page;
            r_startCol <= start_col;
            r_cnt      <= w_cntClamped;
            for (int k = 0; k < MAX_SLOTS; k++) r_codes[k] <= glyph_bus[6*k +: 6];
            r_row      <= 1'b0;
            r_slot     <= 4'd0;
            r_glyphIdx <= 4'd0;
            r_col      <= {1'b0, start_col};
          end
        end
        ST_FETCH: begin
          r_fontSel <= w_code;
          r_fontRow <= r_row;
          r_index   <= 9'(r_glyphIdx);
          r_invalid <= (w_code >= CODE_INVALID_MIN);
          r_wait    <= 4'd0;
        end
        ST_WAIT: r_wait <= r_wait + 4'd1;
        ST_EMIT: begin
          if (w_pushReady) begin
            r_glyphIdx <= w_lastCol ? 4'd0 : (r_glyphIdx + 4'd1);
            r_slot     <= w_nextSlot;
            r_col      <= w_nextCol;
          end
        end
        ST_NEXT_ROW: begin
          if (!w_lastRow) begin
            r_row      <= 1'b1;
            r_fontRow  <= 1'b1;
            r_page     <= r_page + 3'd1;
            r_slot     <= 4'd0;
            r_glyphIdx <= 4'd0;
            r_col      <= {1'b0, r_startCol};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_render.sv
// Scoreboard bench for oled_text_render: a line-level reference model predicts the byte stream.
module tb_oled_text_render;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  line_page;
  logic [6:0]  start_col;
  logic [3:0]  glyph_cnt;
  logic [47:0] glyph_bus;
  logic        busy;
  logic        done;
  logic [5:0]  font_sel;
  logic        font_row;
  logic [8:0]  index;
  logic [7:0]  font_data = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_dc;

  int          nChecks = 0;
  int          nErrors = 0;
  int          doneCount = 0;
  int          dataSeen = 0;
  bit          monEnable = 1'b0;
  bit          randReady = 1'b0;
  bit          prevStall = 1'b0;
  logic [8:0]  prevByte;
  logic [8:0]  expQ [$];

  oled_text_render dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .line_page (line_page),
    .start_col (start_col),
    .glyph_cnt (glyph_cnt),
    .glyph_bus (glyph_bus),
    .busy      (busy),
    .done      (done),
    .font_sel  (font_sel),
    .font_row  (font_row),
    .index     (index),
    .font_data (font_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dc    (out_dc)
  );

  always #5 sys_clk = ~sys_clk;

  // Font ROM: code 0 is the "F" glyph, other codes are a deterministic hash of the address.
  function automatic logic [7:0] romByte(input logic [5:0] sel, input logic row, input logic [8:0] idx);
    logic [7:0] b;
    if (sel == 6'd0 && idx < 9'd8) begin
      case ({row, idx[2:0]})
        4'h0: b = 8'h08; 4'h1: b = 8'hF8; 4'h2: b = 8'h88; 4'h3: b = 8'h88;
        4'h4: b = 8'hE8; 4'h5: b = 8'h08; 4'h6: b = 8'h10; 4'h7: b = 8'h00;
        4'h8: b = 8'h20; 4'h9: b = 8'h3F; 4'hA: b = 8'h20; 4'hB: b = 8'h00;
        4'hC: b = 8'h03; 4'hD: b = 8'h00; 4'hE: b = 8'h00; default: b = 8'h00;
      endcase
    end else begin
      b = 8'(((int'(sel) * 29) + (int'(row) * 113) + (int'(idx) * 11) + 1) ^ 90);
    end
    return b;
  endfunction

  always @(posedge sys_clk) font_data <= romByte(font_sel, font_row, index);

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nErrors++;
    $display("[TB] FAIL %s: actual=event-missing required=event-seen", name);
  endtask

  // Reference model: whole-line expected byte stream from the rendering rules.
  task automatic buildExpected(input logic [2:0] page, input logic [6:0] col,
                               input logic [3:0] cnt, input logic [47:0] bus);
    int n, rows, c, w;
    logic [5:0] code;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    if (n == 0) return;
    rows = (page == 3'd7) ? 1 : 2;
    for (int r = 0; r < rows; r++) begin
      expQ.push_back({1'b0, 8'hB0 | 8'(int'(page) + r)});
      expQ.push_back({1'b0, 4'h0, col[3:0]});
      expQ.push_back({1'b0, 5'b00010, col[6:4]});
      c = int'(col);
      for (int k = 0; k < n; k++) begin
        code = bus[6*k +: 6];
        w = ((code >= 6'd4 && code <= 6'd9) || code == 6'd11) ? 16 : 8;
        for (int i = 0; i < w; i++) begin
          if (c > 127) break;
          expQ.push_back({1'b1, (code >= 6'd15) ? 8'h00 : romByte(code, 1'(r), 9'(i))});
          c++;
        end
      end
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stalled bytes stay put.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge sys_clk);
      if (monEnable) begin
        if (prevStall) begin
          checkOutput("stall_valid", {8'd0, out_valid}, 9'd1);
          checkOutput("stall_data", {out_dc, out_data}, prevByte);
        end
        if (done) doneCount++;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL extra_byte: actual=%h required=none", {out_dc, out_data});
          end else begin
            exp = expQ.pop_front();
            checkOutput("stream_byte", {out_dc, out_data}, exp);
            if (out_dc) dataSeen++;
          end
        end
        prevStall = out_valid && !out_ready;
        prevByte  = {out_dc, out_data};
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  task automatic pulseStart(input logic [2:0] page, input logic [6:0] col,
                            input logic [3:0] cnt, input logic [47:0] bus);
    @(posedge sys_clk);
    #2;
    line_page = page;
    start_col = col;
    glyph_cnt = cnt;
    glyph_bus = bus;
    start     = 1'b1;
    @(posedge sys_clk);
    #2;
    start     = 1'b0;
    line_page = 3'($urandom);
    start_col = 7'($urandom);
    glyph_cnt = 4'($urandom);
    glyph_bus = {16'($urandom), 32'($urandom)};
  endtask

  task automatic applyStimulus(input logic [2:0] page, input logic [6:0] col,
                               input logic [3:0] cnt, input logic [47:0] bus);
    int d0, cyc;
    buildExpected(page, col, cnt, bus);
    d0 = doneCount;
    pulseStart(page, col, cnt, bus);
    cyc = 0;
    while (doneCount == d0 && cyc < 6000) begin
      @(posedge sys_clk);
      cyc++;
    end
    if (doneCount == d0) failNow("done_timeout");
    repeat (4) @(posedge sys_clk);
    #2;
    checkOutput("queue_drained", 9'(expQ.size()), 9'd0);
    checkOutput("done_once", 9'(doneCount - d0), 9'd1);
    checkOutput("idle_after", {7'd0, busy, out_valid}, 9'd0);
    expQ.delete();
  endtask

  task automatic testZeroCount();
    pulseStart(3'd1, 7'd9, 4'd0, 48'h0);
    checkOutput("cnt0_done", {7'd0, done, busy}, 9'b11);
    @(posedge sys_clk);
    #2;
    checkOutput("cnt0_after", {7'd0, done, busy}, 9'b00);
    checkOutput("cnt0_nobytes", {8'd0, out_valid}, 9'd0);
  endtask

  task automatic testResetMidLine();
    int cyc, d0;
    logic [47:0] bus;
    bus = {6'd1, 6'd2, 6'd4, 6'd0, 6'd3, 6'd5, 6'd7, 6'd10};
    buildExpected(3'd2, 7'd16, 4'd8, bus);
    dataSeen = 0;
    d0 = doneCount;
    pulseStart(3'd2, 7'd16, 4'd8, bus);
    cyc = 0;
    while (dataSeen < 5 && cyc < 2000) begin
      @(posedge sys_clk);
      #2;
      cyc++;
    end
    if (dataSeen < 5) failNow("reset_wait_timeout");
    rst = 1'b1;
    monEnable = 1'b0;
    @(posedge sys_clk);
    #2;
    checkOutput("abort_state", {6'd0, out_valid, busy, done}, 9'd0);
    checkOutput("abort_nodone", 9'(doneCount - d0), 9'd0);
    rst = 1'b0;
    expQ.delete();
    monEnable = 1'b1;
    applyStimulus(3'd2, 7'd16, 4'd8, bus);
  endtask

  initial begin
    logic [47:0] bus;
    rst = 1'b1;
    start = 1'b0;
    line_page = 3'd0;
    start_col = 7'd0;
    glyph_cnt = 4'd0;
    glyph_bus = 48'h0;
    repeat (3) @(posedge sys_clk);
    #2;
    checkOutput("reset_flags", {4'd0, busy, done, out_valid, out_dc, font_row}, 9'd0);
    checkOutput("reset_data", {1'b0, out_data}, 9'd0);
    checkOutput("reset_sel", {3'd0, font_sel}, 9'd0);
    checkOutput("reset_index", index, 9'd0);
    rst = 1'b0;
    monEnable = 1'b1;

    $display("[TB] single narrow glyph");
    applyStimulus(3'd2, 7'd0, 4'd1, 48'h0);
    $display("[TB] wide glyph");
    applyStimulus(3'd3, 7'h25, 4'd1, 48'd4);
    $display("[TB] right-edge clipping");
    applyStimulus(3'd1, 7'd120, 4'd2, {36'd0, 6'd0, 6'd4});
    $display("[TB] wide glyph under backpressure");
    randReady = 1'b1;
    applyStimulus(3'd3, 7'h25, 4'd1, 48'd4);
    applyStimulus(3'd0, 7'd100, 4'd5, {18'd0, 6'd20, 6'd11, 6'd0, 6'd2, 6'd6});
    randReady = 1'b0;
    $display("[TB] boundaries");
    testZeroCount();
    bus = {6'd14, 6'd1, 6'd9, 6'd3, 6'd0, 6'd8, 6'd2, 6'd5};
    applyStimulus(3'd5, 7'd7, 4'd12, bus);
    applyStimulus(3'd4, 7'd3, 4'd1, 48'd20);
    applyStimulus(3'd7, 7'd50, 4'd2, {36'd0, 6'd5, 6'd0});
    $display("[TB] reset mid-line");
    testResetMidLine();
    $display("[TB] randomized lines");
    for (int t = 0; t < 8; t++) begin
      randReady = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) bus[6*k +: 6] = 6'($urandom_range(0, 20));
      applyStimulus(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                    4'($urandom_range(0, 15)), bus);
    end
    randReady = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
